// File: rtl/axil_pkg.sv
// Shared encodings for the AXI4-Lite memory arbiter: FSM states and response codes.
package axil_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_arb_timeout.sv
// Watchdog down-counter: reloads while start_i is high, counts down while en_i is high,
// expired_o flags the final allowed cycle.
module axil_arb_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i)
            cnt_d = CW'(TIMEOUT - 1);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= CW'(TIMEOUT - 1);
        else       cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/axil_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the AXI4-Lite write and read paths.
// Optional watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_mem_arbiter
    import axil_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                WREQ,
    input  logic [ADDR_W-1:0]   WADDR,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    output logic                WGNT,
    input  logic                RREQ,
    input  logic [ADDR_W-1:0]   RADDR,
    output logic                RGNT,
    output logic                MEM_EN,
    output logic                MEM_WE,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic [DATA_W-1:0]   MEM_WDATA,
    output logic [DATA_W/8-1:0] MEM_WSTRB,
    input  logic [DATA_W-1:0]   MEM_RDATA,
    input  logic                MEM_ACK,
    input  logic                MEM_ERR,
    output logic                WRESPREADY,
    output logic [1:0]          WRESP,
    output logic                RRESPREADY,
    output logic [1:0]          RRESP,
    output logic [DATA_W-1:0]   RDATA
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic                last_wr_q, last_wr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                wgnt_q, wgnt_d, rgnt_q, rgnt_d;
    logic                wrv_q, wrv_d, rrv_q, rrv_d;
    logic [1:0]          wresp_q, wresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                tmo_expired;
    logic                grant_w;

`ifdef AXIL_ARB_TIMEOUT_EN
    axil_arb_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .start_i   (state_q != ACCESS),
        .en_i      (state_q == ACCESS),
        .expired_o (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 1);
    assign tmo_expired    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wresp_d   = wresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        wgnt_d    = 1'b0;
        rgnt_d    = 1'b0;
        wrv_d     = 1'b0;
        rrv_d     = 1'b0;
        grant_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (WREQ || RREQ) begin
                    // On a tie the path not served last wins.
                    grant_w   = WREQ && (!RREQ || !last_wr_q);
                    state_d   = ACCESS;
                    last_wr_d = grant_w;
                    we_d      = grant_w;
                    wgnt_d    = grant_w;
                    rgnt_d    = !grant_w;
                    addr_d    = grant_w ? WADDR : RADDR;
                    if (grant_w) begin
                        wdata_d = WDATA;
                        wstrb_d = WSTRB;
                    end
                end
            end
            ACCESS: begin
                // An ack in the last allowed cycle takes precedence over the watchdog.
                if (MEM_ACK || tmo_expired) begin
                    state_d = RESP;
                    if (we_q) begin
                        wrv_d   = 1'b1;
                        wresp_d = MEM_ACK ? resp_code(MEM_ERR) : RESP_SLVERR;
                    end else begin
                        rrv_d   = 1'b1;
                        rresp_d = MEM_ACK ? resp_code(MEM_ERR) : RESP_SLVERR;
                        rdata_d = MEM_ACK ? MEM_RDATA : '0;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wgnt_q    <= 1'b0;
            rgnt_q    <= 1'b0;
            wrv_q     <= 1'b0;
            rrv_q     <= 1'b0;
            wresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wgnt_q    <= wgnt_d;
            rgnt_q    <= rgnt_d;
            wrv_q     <= wrv_d;
            rrv_q     <= rrv_d;
            wresp_q   <= wresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign WGNT       = wgnt_q;
    assign RGNT       = rgnt_q;
    assign MEM_EN     = (state_q == ACCESS);
    assign MEM_WE     = we_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_WDATA  = wdata_q;
    assign MEM_WSTRB  = wstrb_q;
    assign WRESPREADY = wrv_q;
    assign WRESP      = wresp_q;
    assign RRESPREADY = rrv_q;
    assign RRESP      = rresp_q;
    assign RDATA      = rdata_q;
endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Scoreboard bench for axil_mem_arbiter; timeout case runs only when AXIL_ARB_TIMEOUT_EN is defined.
module tb_axil_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        WREQ, RREQ, MEM_ACK, MEM_ERR;
    logic [7:0]  WADDR, RADDR, MEM_ADDR;
    logic [31:0] WDATA, MEM_RDATA, MEM_WDATA, RDATA;
    logic [3:0]  WSTRB, MEM_WSTRB;
    logic        WGNT, RGNT, MEM_EN, MEM_WE, WRESPREADY, RRESPREADY;
    logic [1:0]  WRESP, RRESP;

    axil_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .WREQ(WREQ), .WADDR(WADDR), .WDATA(WDATA), .WSTRB(WSTRB), .WGNT(WGNT),
        .RREQ(RREQ), .RADDR(RADDR), .RGNT(RGNT),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_WSTRB(MEM_WSTRB), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .MEM_ERR(MEM_ERR),
        .WRESPREADY(WRESPREADY), .WRESP(WRESP), .RRESPREADY(RRESPREADY), .RRESP(RRESP),
        .RDATA(RDATA)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    bit   gnt_q[$];

    int          ack_delay = 2;
    logic        err_cfg   = 1'b0;
    logic [31:0] rdata_cfg = '0;
    int          acc_cnt   = 0;

    // Memory model: acks ack_delay cycles into each access (never if negative).
    always @(negedge clk) begin
        if (MEM_EN && !MEM_ACK) begin
            if (acc_cnt == ack_delay) begin
                MEM_ACK   = 1'b1;
                MEM_ERR   = err_cfg;
                MEM_RDATA = rdata_cfg;
            end
            acc_cnt++;
        end else begin
            MEM_ACK = 1'b0;
            MEM_ERR = 1'b0;
            acc_cnt = 0;
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        bit   g;
        if (!reset) begin
            if (WGNT || RGNT) begin
                check("gnt_excl", 64'(WGNT & RGNT), 64'd0);
                if (gnt_q.size() == 0) check("gnt_unexp", 64'd1, 64'd0);
                else begin
                    g = gnt_q.pop_front();
                    check("gnt_dir", 64'(WGNT), 64'(g));
                end
            end
            if (WRESPREADY || RRESPREADY) begin
                check("resp_excl", 64'(WRESPREADY & RRESPREADY), 64'd0);
                if (exp_q.size() == 0) check("resp_unexp", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("resp_dir", 64'(WRESPREADY), 64'(e.wr));
                    if (e.wr) check("wresp", 64'(WRESP), 64'(e.resp));
                    else begin
                        check("rresp", 64'(RRESP), 64'(e.resp));
                        check("rdata", 64'(RDATA), 64'(e.data));
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || gnt_q.size() != 0) begin
            check("drain_timeout", 64'd1, 64'd0);
            exp_q.delete();
            gnt_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic err);
        exp_t e;
        err_cfg = err;
        e.wr = 1'b1; e.resp = err ? 2'b10 : 2'b00; e.data = '0;
        exp_q.push_back(e);
        gnt_q.push_back(1'b1);
        WREQ = 1'b1; WADDR = a; WDATA = d; WSTRB = s;
        @(negedge clk);
        check("wr_gnt", 64'(WGNT), 64'd1);
        check("wr_en", 64'(MEM_EN), 64'd1);
        check("wr_we", 64'(MEM_WE), 64'd1);
        check("wr_addr", 64'(MEM_ADDR), 64'(a));
        check("wr_wdata", 64'(MEM_WDATA), 64'(d));
        check("wr_wstrb", 64'(MEM_WSTRB), 64'(s));
        WREQ = 1'b0;
        wait_drain(50);
        err_cfg = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        rdata_cfg = d;
        e.wr = 1'b0; e.resp = 2'b00; e.data = d;
        exp_q.push_back(e);
        gnt_q.push_back(1'b0);
        RREQ = 1'b1; RADDR = a;
        @(negedge clk);
        check("rd_gnt", 64'(RGNT), 64'd1);
        check("rd_we", 64'(MEM_WE), 64'd0);
        check("rd_addr", 64'(MEM_ADDR), 64'(a));
        RREQ = 1'b0;
        wait_drain(50);
    endtask

    initial begin
        exp_t e;
        int   n;
        reset = 1'b1;
        WREQ = 0; RREQ = 0; WADDR = 0; RADDR = 0; WDATA = 0; WSTRB = 0;
        MEM_ACK = 0; MEM_ERR = 0; MEM_RDATA = 0;
        repeat (3) @(negedge clk);
        check("rst_en", 64'(MEM_EN), 64'd0);
        check("rst_gnt", 64'({WGNT, RGNT}), 64'd0);
        check("rst_pulse", 64'({WRESPREADY, RRESPREADY}), 64'd0);
        check("rst_rdata", 64'(RDATA), 64'd0);
        check("rst_resp", 64'({WRESP, RRESP}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Contention: both held high, expect W,R,W,R
        ack_delay = 1;
        rdata_cfg = 32'hA5A5_0001;
        for (int i = 0; i < 4; i++) begin
            gnt_q.push_back(i % 2 == 0);
            e.wr = (i % 2 == 0); e.resp = 2'b00; e.data = rdata_cfg;
            exp_q.push_back(e);
        end
        WREQ = 1; RREQ = 1; WADDR = 8'h30; RADDR = 8'h34; WDATA = 32'h1111_2222; WSTRB = 4'hF;
        n = 0;
        while (gnt_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        WREQ = 0; RREQ = 0;
        wait_drain(50);

        ack_delay = 2;
        do_write(8'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        do_read(8'h24, 32'h1234_5678);
        check("rdata_hold", 64'(RDATA), 64'h1234_5678);
        do_write(8'h44, 32'h0BAD_F00D, 4'h3, 1'b1);
        check("wresp_hold", 64'(WRESP), 64'd2);
        check("rresp_hold", 64'(RRESP), 64'd0);

`ifdef AXIL_ARB_TIMEOUT_EN
        ack_delay = -1;
        rdata_cfg = 32'hFFFF_FFFF;
        e.wr = 1'b0; e.resp = 2'b10; e.data = '0;
        exp_q.push_back(e);
        gnt_q.push_back(1'b0);
        RREQ = 1; RADDR = 8'h60;
        @(negedge clk);
        check("tmo_gnt", 64'(RGNT), 64'd1);
        RREQ = 0;
        repeat (15) @(negedge clk);
        check("tmo_en_hold", 64'(MEM_EN), 64'd1);
        @(negedge clk);
        check("tmo_en_drop", 64'(MEM_EN), 64'd0);
        wait_drain(10);
        ack_delay = 2;
`endif

        // Mid-access reset: access abandoned, no response, then tie goes to W
        ack_delay = -1;
        gnt_q.push_back(1'b1);
        WREQ = 1; WADDR = 8'h50; WDATA = 32'hCAFE_0000; WSTRB = 4'hC;
        @(negedge clk);
        check("mr_gnt", 64'(WGNT), 64'd1);
        WREQ = 0;
        repeat (2) @(negedge clk);
        check("mr_en_pre", 64'(MEM_EN), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_en", 64'(MEM_EN), 64'd0);
        check("mr_mem", 64'({MEM_WE, MEM_ADDR, MEM_WSTRB}), 64'd0);
        check("mr_wdata", 64'(MEM_WDATA), 64'd0);
        check("mr_rdata", 64'(RDATA), 64'd0);
        check("mr_resp", 64'({WRESP, RRESP, WRESPREADY, RRESPREADY}), 64'd0);
        reset = 1'b0;
        ack_delay = 2;
        @(negedge clk);
        check("mr_no_pulse", 64'({WRESPREADY, RRESPREADY}), 64'd0);
        e.wr = 1'b1; e.resp = 2'b00; e.data = '0;
        exp_q.push_back(e);
        gnt_q.push_back(1'b1);
        WREQ = 1; RREQ = 1; WADDR = 8'h70; RADDR = 8'h74;
        @(negedge clk);
        check("mr_tie_w", 64'(WGNT), 64'd1);
        WREQ = 0; RREQ = 0;
        wait_drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_mem_arbiter.md
# axil_mem_arbiter

Arbitrates the single backing-memory port of the AXI4-Lite slave between the write path (AW/W channels) and the read path (AR channel). It uses round-robin priority and sequences one memory access at a time. It routes the completion status to the B channel as `WRESPREADY`/`WRESP`, and to the R channel as `RRESPREADY`/`RRESP`/`RDATA`. A watchdog can turn a hung memory access into an SLVERR response.

## Interface
- `ADDR_W`, default 8: byte-address width.
- `DATA_W`, default 32: data width; must be 32 or 64.
- `TIMEOUT`, default 16: cycles allowed for `MEM_ACK`; must be ≥2; used only when `AXIL_ARB_TIMEOUT_EN` is defined.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `WREQ` in 1: write request from the write path.
- `WADDR` in ADDR_W: write address.
- `WDATA` in DATA_W: write data.
- `WSTRB` in DATA_W/8: write byte strobes.
- `WGNT` out 1: one-cycle pulse, write request accepted.
- `RREQ` in 1: read request from the read path.
- `RADDR` in ADDR_W: read address.
- `RGNT` out 1: one-cycle pulse, read request accepted.
- `MEM_EN` out 1: memory access active.
- `MEM_WE` out 1: 1 = write, 0 = read.
- `MEM_ADDR` out ADDR_W: latched address.
- `MEM_WDATA` out DATA_W: latched write data.
- `MEM_WSTRB` out DATA_W/8: latched strobes.
- `MEM_RDATA` in DATA_W: read data, valid with `MEM_ACK`.
- `MEM_ACK` in 1: access complete.
- `MEM_ERR` in 1: access failed, qualified by `MEM_ACK`.
- `WRESPREADY` out 1: one-cycle pulse to the B channel.
- `WRESP` out 2: write status, valid with `WRESPREADY`.
- `RRESPREADY` out 1: one-cycle pulse to the R channel.
- `RRESP` out 2: read status.
- `RDATA` out DATA_W: read data, valid with `RRESPREADY`.

## Operation
- FSM states:
  - IDLE: sample `WREQ`/`RREQ`.
    - Exactly one request asserted → grant it.
    - Both asserted → grant the path not served last.
    - Go to ACCESS.
  - ACCESS: hold `MEM_EN`=1 with latched `MEM_WE`/`MEM_ADDR`/`MEM_WDATA`/`MEM_WSTRB` constant.
    - On `MEM_ACK`: capture status and, for a read, `MEM_RDATA`, then go to RESP.
  - RESP: pulse `WRESPREADY` or `RRESPREADY` for one cycle according to the latched direction, then go to IDLE.
- Priority bit `last_wr`:
  - Updated on every grant.
  - Reset value 0, so write wins the first tie.
- Status codes:
  - `MEM_ACK` with `MEM_ERR`=0 → OKAY (2'b00).
  - `MEM_ACK` with `MEM_ERR`=1 → SLVERR (2'b10).
- Requester obligations:
  - Hold REQ and its address/data stable until the GNT pulse.
  - REQ still high in the first IDLE cycle after RESP counts as a new request.
- `MEM_ACK` outside ACCESS is ignored.
- Reset, including mid-access:
  - State → IDLE, `last_wr` → 0.
  - All outputs → 0, including `RDATA`, `WRESP`, `RRESP` and `MEM_*`.
  - The in-flight access is abandoned with no response pulse.

## Timing
- Request seen high in IDLE at cycle N:
  - GNT pulses at N+1.
  - `MEM_EN` goes high at N+1, with outputs registered.
- `MEM_ACK` sampled high at cycle M: `MEM_EN` is low at M+1 and the response pulse occurs at M+1.
- Earliest next grant: the response cycle plus 1 (IDLE), so there are at least 3 cycles per access.
- `WRESP`/`RRESP`/`RDATA` hold their value after the pulse until the next response of that type.
- `WGNT` and `RGNT` are never high together.
- `WRESPREADY` and `RRESPREADY` are never high together.

## Configuration
- `AXIL_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS.
  - If `MEM_ACK` has not arrived after `TIMEOUT` ACCESS cycles, `MEM_EN` drops and the FSM goes to RESP with SLVERR and `RDATA`=0.
  - `MEM_ACK` in the final cycle wins over the timeout.
- `AXIL_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - ACCESS waits indefinitely for `MEM_ACK`.

## Structure
- Shared package `axil_pkg`:
  - FSM encodings IDLE=2'b00, ACCESS=2'b01, RESP=2'b10.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Sub-module `axil_arb_timeout`: loadable down-counter with `start`/`expired`, instantiated only under the macro.

## Test plan
- Single write: `WREQ`=1 with `WADDR`=0x10, `WDATA`=0xDEADBEEF, `WSTRB`=0xF; memory acks 2 cycles later → `WGNT` at N+1, `MEM_WE`=1 with the latched values, `WRESPREADY` pulse with `WRESP`=00.
- Single read: `RADDR`=0x24, `MEM_RDATA`=0x12345678 with `MEM_ACK` → `RRESPREADY` pulse, `RDATA`=0x12345678, `RRESP`=00.
- Contention: `WREQ` and `RREQ` held high continuously → grants alternate W, R, W, R, and the first grant after reset is W.
- Error: `MEM_ACK` with `MEM_ERR`=1 on a write → `WRESP`=2'b10.
- Timeout (macro on, `TIMEOUT`=16): no ack → `MEM_EN` drops after 16 ACCESS cycles, `RRESPREADY` pulses with `RRESP`=2'b10 and `RDATA`=0.
- Mid-access reset: `reset`=1 during ACCESS → all outputs 0 next cycle, no response pulse; then a tie is granted to W.
